// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants and stage-register types for alu_issue_pipe.
//               Holds the datapath and register-file sizing, the instruction
//               field positions and the EX/WB stage register layouts.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int DW   = 4;   // datapath width, matches the ALU
  localparam int NREG = 8;   // architectural registers, r0 reads as zero
  localparam int AW   = 3;   // register index width
  localparam int IW   = 13;  // instruction width
  localparam int OPW  = 3;   // ALU control width

  // Instruction field positions
  localparam int LI_BIT = 12;
  localparam int OP_HI  = 11;
  localparam int OP_LO  = 9;
  localparam int RD_HI  = 8;
  localparam int RD_LO  = 6;
  localparam int RS1_HI = 5;
  localparam int RS1_LO = 3;
  localparam int RS2_HI = 2;
  localparam int RS2_LO = 0;
  localparam int IMM_HI = DW - 1;
  localparam int IMM_LO = 0;

  // EX stage: decoded instruction plus resolved operands
  typedef struct packed {
    logic           li;
    logic [OPW-1:0] op;
    logic [AW-1:0]  rd;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } ex_stage_t;

  // WB stage: captured result waiting to retire
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] x;
    logic          co;
  } wb_stage_t;

endpackage
`default_nettype wire

// File: rtl/pipe_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pipe_regfile
// Description : NREG x DW register file with two operand read ports, one
//               debug read port (all combinational) and one synchronous write
//               port. Register 0 is never written and always reads zero.
// Ports       : clk, rst_n (async active-low clear)
//               we, waddr, wdata      - write port
//               raddr1/rdata1         - operand read port 1
//               raddr2/rdata2         - operand read port 2
//               dbg_addr/dbg_data     - debug read port
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_regfile
  import pipe_pkg::*;
#(
  parameter int RF_DW   = DW,
  parameter int RF_NREG = NREG,
  parameter int RF_AW   = AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [RF_AW-1:0] waddr,
  input  logic [RF_DW-1:0] wdata,
  input  logic [RF_AW-1:0] raddr1,
  output logic [RF_DW-1:0] rdata1,
  input  logic [RF_AW-1:0] raddr2,
  output logic [RF_DW-1:0] rdata2,
  input  logic [RF_AW-1:0] dbg_addr,
  output logic [RF_DW-1:0] dbg_data
);

  logic [RF_DW-1:0] regs [RF_NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // r0 is forced to zero on every read port, independent of storage
  assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pipe
// Description : Two-stage issue/writeback pipeline around an external
//               combinational ALU. Instructions are accepted on a valid/ready
//               handshake, operands are read with EX/WB forwarding, the EX
//               register drives the ALU and the WB register retires results
//               on a back-pressured result stream into the register file.
// Ports       : clk, rst_n                         - clock, async active-low reset
//               in_valid/in_ready/in_instr         - instruction input stream
//               alu_a/alu_b/alu_ctrl               - ALU operands (EX register)
//               alu_x/alu_co                       - ALU result and carry
//               res_valid/res_ready/res_rd/res_x/res_co - result stream
//               flag_c                             - carry of last retired instr
//               dbg_addr/dbg_data                  - raw register-file read
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_pipe
  import pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_instr,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_ctrl,
  input  logic [DW-1:0]  alu_x,
  input  logic           alu_co,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [AW-1:0]  res_rd,
  output logic [DW-1:0]  res_x,
  output logic           res_co,
  output logic           flag_c,
  input  logic [AW-1:0]  dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  ex_stage_t     ex_q, ex_d;
  wb_stage_t     wb_q, wb_d;
  logic          ex_valid, wb_valid;
  logic          stall, accept, retire;
  logic [AW-1:0] rs1, rs2;
  logic [DW-1:0] rf_rs1, rf_rs2;
  logic [DW-1:0] ex_result;

  // Operand select: r0, then the younger EX result, then WB, then the file.
  // WB forwarding also covers a retire to the same register on this edge.
  function automatic logic [DW-1:0] sel_operand(
    input logic [AW-1:0] rs,
    input logic          exv,
    input logic [AW-1:0] exrd,
    input logic [DW-1:0] exres,
    input logic          wbv,
    input logic [AW-1:0] wbrd,
    input logic [DW-1:0] wbx,
    input logic [DW-1:0] rfv
  );
    logic [DW-1:0] val;
    if (rs == '0)
      val = '0;
    else if (exv && (exrd == rs))
      val = exres;
    else if (wbv && (wbrd == rs))
      val = wbx;
    else
      val = rfv;
    return val;
  endfunction

  assign stall    = wb_valid & ~res_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign retire   = wb_valid & res_ready;

  assign rs1 = in_instr[RS1_HI:RS1_LO];
  assign rs2 = in_instr[RS2_HI:RS2_LO];

  // An li carries its immediate in ex_b and bypasses the ALU result
  assign ex_result = ex_q.li ? ex_q.b : alu_x;

  always_comb begin
    ex_d    = '0;
    ex_d.li = in_instr[LI_BIT];
    ex_d.op = in_instr[OP_HI:OP_LO];
    ex_d.rd = in_instr[RD_HI:RD_LO];
    if (in_instr[LI_BIT]) begin
      ex_d.a = '0;
      ex_d.b = in_instr[IMM_HI:IMM_LO];
    end else begin
      ex_d.a = sel_operand(rs1, ex_valid, ex_q.rd, ex_result,
                           wb_valid, wb_q.rd, wb_q.x, rf_rs1);
      ex_d.b = sel_operand(rs2, ex_valid, ex_q.rd, ex_result,
                           wb_valid, wb_q.rd, wb_q.x, rf_rs2);
    end
  end

  always_comb begin
    wb_d    = '0;
    wb_d.rd = ex_q.rd;
    wb_d.x  = ex_result;
    wb_d.co = ex_q.li ? 1'b0 : alu_co;
  end

  // EX stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (!stall) begin
      ex_valid <= accept;
      if (accept) begin
        ex_q <= ex_d;
      end
    end
  end

  // WB stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_q     <= '0;
    end else if (!stall) begin
      wb_valid <= ex_valid;
      wb_q     <= wb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c <= 1'b0;
    end else if (retire) begin
      flag_c <= wb_q.co;
    end
  end

  pipe_regfile #(
    .RF_DW   (DW),
    .RF_NREG (NREG),
    .RF_AW   (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (retire),
    .waddr    (wb_q.rd),
    .wdata    (wb_q.x),
    .raddr1   (rs1),
    .rdata1   (rf_rs1),
    .raddr2   (rs2),
    .rdata2   (rf_rs2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_a     = ex_q.a;
  assign alu_b     = ex_q.b;
  assign alu_ctrl  = ex_q.op;
  assign res_valid = wb_valid;
  assign res_rd    = wb_q.rd;
  assign res_x     = wb_q.x;
  assign res_co    = wb_q.co;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_pipe
// Description : Directed self-checking bench for alu_issue_pipe with a small
//               behavioural ALU (0:add, 1:and, 2:or, 3:xor, others:add).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_instr;
  logic [3:0]  alu_a, alu_b, alu_x;
  logic [2:0]  alu_ctrl;
  logic        alu_co;
  logic        res_valid, res_ready;
  logic [2:0]  res_rd;
  logic [3:0]  res_x;
  logic        res_co, flag_c;
  logic [2:0]  dbg_addr;
  logic [3:0]  dbg_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_x     (alu_x),
    .alu_co    (alu_co),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_rd    (res_rd),
    .res_x     (res_x),
    .res_co    (res_co),
    .flag_c    (flag_c),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // Behavioural ALU
  always_comb begin
    {alu_co, alu_x} = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_ctrl)
      3'd1: {alu_co, alu_x} = {1'b0, alu_a & alu_b};
      3'd2: {alu_co, alu_x} = {1'b0, alu_a | alu_b};
      3'd3: {alu_co, alu_x} = {1'b0, alu_a ^ alu_b};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] li_i(input logic [2:0] rd, input logic [3:0] imm);
    return {1'b1, 3'd0, rd, 2'b00, imm};
  endfunction

  function automatic logic [12:0] op_i(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
    return {1'b0, op, rd, rs1, rs2};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic dbg_check(input string tag, input logic [2:0] addr, input logic [3:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;
    dbg_addr  = '0;
    step();
    step();
    rst_n = 1'b1;

    // ---- 1: reset mid-stream discards an in-flight li r4=3
    in_valid = 1'b1;
    in_instr = li_i(3'd4, 4'd3);
    step();
    in_valid = 1'b0;
    mid();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    mid();
    check("rst_res_valid", res_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_res_rd", res_rd, 0);
    check("rst_res_x", res_x, 0);
    check("rst_res_co", res_co, 0);
    check("rst_flag_c", flag_c, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_check($sformatf("rst_dbg_r%0d", i), i[2:0], 4'd0);
    end
    step();
    mid();
    dbg_check("rst_no_wb_r4", 3'd4, 4'd0);

    // ---- 2: immediate load li r1=5
    step();
    in_valid = 1'b1;
    in_instr = li_i(3'd1, 4'd5);
    step();
    in_valid = 1'b0;
    mid();
    check("li_alu_b", alu_b, 5);
    check("li_alu_a", alu_a, 0);
    step();
    mid();
    check("li_res_valid", res_valid, 1);
    check("li_res_rd", res_rd, 1);
    check("li_res_x", res_x, 5);
    check("li_res_co", res_co, 0);
    step();
    mid();
    dbg_check("li_dbg_r1", 3'd1, 4'd5);
    check("li_res_idle", res_valid, 0);

    // ---- 3: forwarding chain li r1=7, li r2=9, xor r3=r1^r2
    in_valid = 1'b1;
    in_instr = li_i(3'd1, 4'd7);
    step();
    in_instr = li_i(3'd2, 4'd9);
    step();
    in_instr = op_i(3'd3, 3'd3, 3'd1, 3'd2);
    mid();
    check("fw_res_valid0", res_valid, 1);
    check("fw_res_x0", res_x, 7);
    step();
    in_valid = 1'b0;
    mid();
    check("fw_alu_a", alu_a, 7);
    check("fw_alu_b", alu_b, 9);
    check("fw_alu_ctrl", alu_ctrl, 3);
    check("fw_res_valid1", res_valid, 1);
    check("fw_res_x1", res_x, 9);
    step();
    mid();
    check("fw_res_valid2", res_valid, 1);
    check("fw_res_rd2", res_rd, 3);
    check("fw_res_x2", res_x, 4'hE);
    step();
    mid();
    check("fw_res_done", res_valid, 0);
    dbg_check("fw_dbg_r3", 3'd3, 4'hE);

    // ---- 4: back-pressure with li r4=2, add r5=r4+r1, li r6=C
    in_valid = 1'b1;
    in_instr = li_i(3'd4, 4'd2);
    step();
    in_instr = op_i(3'd0, 3'd5, 3'd4, 3'd1);
    step();
    in_instr  = li_i(3'd6, 4'hC);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("bp_in_ready", in_ready, 0);
      check("bp_res_valid", res_valid, 1);
      check("bp_res_rd", res_rd, 4);
      check("bp_res_x", res_x, 2);
      check("bp_alu_a", alu_a, 2);
      check("bp_alu_b", alu_b, 7);
      check("bp_alu_ctrl", alu_ctrl, 0);
      check("bp_flag_c", flag_c, 0);
      dbg_check("bp_dbg_r4", 3'd4, 4'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_in_ready_rel", in_ready, 1);
    step();
    in_valid = 1'b0;
    mid();
    check("bp_ret1_rd", res_rd, 5);
    check("bp_ret1_x", res_x, 9);
    check("bp_ret1_valid", res_valid, 1);
    dbg_check("bp_dbg_r4_w", 3'd4, 4'd2);
    step();
    mid();
    check("bp_ret2_rd", res_rd, 6);
    check("bp_ret2_x", res_x, 4'hC);
    dbg_check("bp_dbg_r5_w", 3'd5, 4'd9);
    step();
    mid();
    check("bp_no_dup", res_valid, 0);
    dbg_check("bp_dbg_r6_w", 3'd6, 4'hC);

    // ---- 5: r0 protection, li r0=F then xor r7 = r0 ^ r1
    in_valid = 1'b1;
    in_instr = li_i(3'd0, 4'hF);
    step();
    in_instr = op_i(3'd3, 3'd7, 3'd0, 3'd1);
    step();
    in_valid = 1'b0;
    mid();
    check("r0_res_rd", res_rd, 0);
    check("r0_res_x", res_x, 4'hF);
    check("r0_alu_a", alu_a, 0);
    check("r0_alu_b", alu_b, 7);
    step();
    mid();
    dbg_check("r0_dbg", 3'd0, 4'd0);
    check("r0_next_x", res_x, 7);
    step();

    // ---- 6: carry flag, li r2=F, li r4=1, add r5=r2+r4, li r6=3
    in_valid = 1'b1;
    in_instr = li_i(3'd2, 4'hF);
    step();
    in_instr = li_i(3'd4, 4'd1);
    step();
    in_instr = op_i(3'd0, 3'd5, 3'd2, 3'd4);
    step();
    in_instr = li_i(3'd6, 4'd3);
    mid();
    check("cy_alu_a", alu_a, 4'hF);
    check("cy_alu_b", alu_b, 1);
    step();
    in_valid = 1'b0;
    mid();
    check("cy_res_rd", res_rd, 5);
    check("cy_res_x", res_x, 0);
    check("cy_res_co", res_co, 1);
    check("cy_flag_before", flag_c, 0);
    step();
    mid();
    check("cy_flag_set", flag_c, 1);
    check("cy_li_co", res_co, 0);
    step();
    mid();
    check("cy_flag_clr", flag_c, 0);
    dbg_check("cy_dbg_r5", 3'd5, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
